vga_draw_engine: RTL



---
 rtl/vga_draw_pkg.sv | 34 +++
 rtl/vga_draw_if.sv | 16 +
 rtl/vga_draw_walker.sv | 91 +++++++++
 rtl/vga_draw_engine.sv | 120 ++++++++++++
 4 files changed

// File: rtl/vga_draw_pkg.sv
// rtl/vga_draw_pkg.sv - shared op codes, glyph codes and FSM states for the draw engine
package vga_draw_pkg;

    typedef enum logic [1:0] {
        OP_BOX   = 2'd0,
        OP_FILL  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_SHOW  = 2'd3
    } op_t;

    localparam logic [3:0] GLYPH_BLANK = 4'd0;
    localparam logic [3:0] GLYPH_VERT  = 4'd2;
    localparam logic [3:0] GLYPH_HORZ  = 4'd3;
    localparam logic [3:0] GLYPH_TL    = 4'd6;
    localparam logic [3:0] GLYPH_TR    = 4'd7;
    localparam logic [3:0] GLYPH_BR    = 4'd8;
    localparam logic [3:0] GLYPH_BL    = 4'd9;
    localparam logic [3:0] GLYPH_MAX   = GLYPH_BL;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_SKIP, S_CLR, S_SHOW, S_DONE, S_ERR
    } state_t;

    function automatic logic [3:0] box_glyph(input logic top, input logic bottom,
                                             input logic left, input logic right);
        if (top && left)          return GLYPH_TL;
        else if (top && right)    return GLYPH_TR;
        else if (bottom && right) return GLYPH_BR;
        else if (bottom && left)  return GLYPH_BL;
        else if (top || bottom)   return GLYPH_HORZ;
        else                      return GLYPH_VERT;
    endfunction

endpackage

// File: rtl/vga_draw_if.sv
// rtl/vga_draw_if.sv - drawing command channel between UI logic and the draw engine
interface vga_draw_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [6:0] cmd_x;
    logic [5:0] cmd_y;
    logic [6:0] cmd_w;
    logic [5:0] cmd_h;
    logic [3:0] cmd_glyph;

    modport master (output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_glyph,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_glyph,
                    output cmd_ready);
endinterface

// File: rtl/vga_draw_walker.sv
// rtl/vga_draw_walker.sv - raster cell walker; outputs describe the cell entered on this edge
module vga_draw_walker
    import vga_draw_pkg::*;
#(
    parameter int WIDTH  = 120,
    parameter int HEIGHT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        box,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    input  logic [6:0]  w,
    input  logic [5:0]  h,
    output logic [15:0] addr,
    output logic        clipped,
    output logic        last,
    output logic        top,
    output logic        bottom,
    output logic        left,
    output logic        right
);
    logic [6:0]  col_q, x_q, w_q, n_col, sel_x, sel_w;
    logic [5:0]  row_q, y_q, h_q, n_row, sel_y, sel_h;
    logic [15:0] base_q, n_base;
    logic        box_q;
    logic [7:0]  cx, cy;

    always_comb begin
        sel_x  = load ? x : x_q;
        sel_y  = load ? y : y_q;
        sel_w  = load ? w : w_q;
        sel_h  = load ? h : h_q;
        n_col  = col_q;
        n_row  = row_q;
        n_base = base_q;
        if (load) begin
            n_col  = 7'd0;
            n_row  = 6'd0;
            // constant-coefficient product, reduces to a few adders
            n_base = 16'(y) * 16'(WIDTH);
        end else if (step) begin
            if (col_q == w_q - 7'd1) begin
                n_col  = 7'd0;
                n_row  = row_q + 6'd1;
                n_base = base_q + 16'(WIDTH);
            end else if (box_q && col_q == 7'd0 && row_q != 6'd0 && row_q != h_q - 6'd1) begin
                n_col = w_q - 7'd1;
            end else begin
                n_col = col_q + 7'd1;
            end
        end
        cx      = {1'b0, sel_x} + {1'b0, n_col};
        cy      = {2'b00, sel_y} + {2'b00, n_row};
        addr    = n_base + {8'h00, cx};
        clipped = (cx >= 8'(WIDTH)) || (cy >= 8'(HEIGHT));
        top     = (n_row == 6'd0);
        bottom  = (n_row == sel_h - 6'd1);
        left    = (n_col == 7'd0);
        right   = (n_col == sel_w - 7'd1);
        last    = (row_q == h_q - 6'd1) && (col_q == w_q - 7'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            w_q    <= '0;
            h_q    <= '0;
            box_q  <= 1'b0;
        end else begin
            if (load || step) begin
                col_q  <= n_col;
                row_q  <= n_row;
                base_q <= n_base;
            end
            if (load) begin
                x_q   <= x;
                y_q   <= y;
                w_q   <= w;
                h_q   <= h;
                box_q <= box;
            end
        end
    end
endmodule

// File: rtl/vga_draw_engine.sv
// rtl/vga_draw_engine.sv - command-driven box/fill/clear/show sequencer; VGA_DRAW_AUTOSHOW_EN adds a trailing refresh
module vga_draw_engine
    import vga_draw_pkg::*;
#(
    parameter int WIDTH  = 120,
    parameter int HEIGHT = 40
) (
    input  logic        clk,
    input  logic        rst,
    vga_draw_if.slave   cmd,
    output logic        done,
    output logic        err,
    output logic        vga_write,
    output logic [15:0] vga_addr,
    output logic [15:0] vga_data,
    output logic        vga_clear,
    output logic        vga_activate
);
    state_t      state_q, state_d;
    logic        load, step, bad, op_box_q, sel_box;
    logic [3:0]  glyph_q, sel_glyph, cell_glyph;
    logic [15:0] walk_addr;
    logic        clipped, last, top, bottom, left, right;

    vga_draw_walker #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_walker (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .box     (cmd.cmd_op == OP_BOX),
        .x       (cmd.cmd_x),
        .y       (cmd.cmd_y),
        .w       (cmd.cmd_w),
        .h       (cmd.cmd_h),
        .addr    (walk_addr),
        .clipped (clipped),
        .last    (last),
        .top     (top),
        .bottom  (bottom),
        .left    (left),
        .right   (right)
    );

    always_comb begin
        bad = ((cmd.cmd_op == OP_BOX)  && (cmd.cmd_w < 7'd2 || cmd.cmd_h < 6'd2)) ||
              ((cmd.cmd_op == OP_FILL) && (cmd.cmd_w == 7'd0 || cmd.cmd_h == 6'd0 ||
                                           cmd.cmd_glyph > GLYPH_MAX));
        sel_box    = load ? (cmd.cmd_op == OP_BOX) : op_box_q;
        sel_glyph  = load ? cmd.cmd_glyph : glyph_q;
        cell_glyph = sel_box ? box_glyph(top, bottom, left, right) : sel_glyph;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_op == OP_CLEAR)     state_d = S_CLR;
                    else if (cmd.cmd_op == OP_SHOW) state_d = S_SHOW;
                    else if (bad)                   state_d = S_ERR;
                    else begin
                        load    = 1'b1;
                        state_d = clipped ? S_SKIP : S_SETUP;
                    end
                end
            end
            S_SETUP: state_d = S_STROBE;
            S_STROBE, S_SKIP: begin
                if (last) begin
`ifdef VGA_DRAW_AUTOSHOW_EN
                    state_d = S_SHOW;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    step    = 1'b1;
                    state_d = clipped ? S_SKIP : S_SETUP;
                end
            end
            S_CLR, S_SHOW:  state_d = S_DONE;
            S_DONE, S_ERR:  state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
    end

    // strobes are decoded from the next state so every output leaves a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cmd.cmd_ready <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            vga_write     <= 1'b0;
            vga_clear     <= 1'b0;
            vga_activate  <= 1'b0;
            vga_addr      <= '0;
            vga_data      <= '0;
            op_box_q      <= 1'b0;
            glyph_q       <= GLYPH_BLANK;
        end else begin
            state_q       <= state_d;
            cmd.cmd_ready <= (state_d == S_IDLE);
            done          <= (state_d == S_DONE);
            err           <= (state_d == S_ERR);
            vga_write     <= (state_d == S_STROBE);
            vga_clear     <= (state_d == S_CLR);
            vga_activate  <= (state_d == S_SHOW);
            if (load) begin
                op_box_q <= (cmd.cmd_op == OP_BOX);
                glyph_q  <= cmd.cmd_glyph;
            end
            if (load || step) begin
                vga_addr <= walk_addr;
                vga_data <= {12'h000, cell_glyph};
            end
        end
    end
endmodule
